// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring division, one quotient bit per clock,
// valid/ready handshake on both sides. Special-case, range and truncation behaviour match the multiplier.
module fp_div_seq #(
    parameter int unsigned QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SPEC_NONE = 2'd0;
    localparam logic [1:0] SPEC_INF  = 2'd1;
    localparam logic [1:0] SPEC_ZERO = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       spec_q, spec_d;
    logic             sign_q, sign_d;
    logic [7:0]       ea_q, ea_d;
    logic [7:0]       eb_q, eb_d;
    logic [23:0]      mb_q, mb_d;
    logic [24:0]      rem_q, rem_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             norm_q, norm_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      quotient_q, quotient_d;
    logic             exception_q, exception_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rem_ge_s;
    logic [24:0]      rem_sel_s;
    logic signed [9:0] exp_raw_s;
    logic signed [9:0] exp_adj_s;
    logic [22:0]      mant_s;

    // Restoring step and normalization datapath, shared by the FSM below
    always_comb begin
        rem_ge_s  = (rem_q >= {1'b0, mb_q});
        rem_sel_s = rem_ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
        exp_raw_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        if (q_q[QBITS-1]) begin
            exp_adj_s = exp_raw_s;
            mant_s    = q_q[QBITS-2:1];
        end else begin
            exp_adj_s = exp_raw_s - 10'sd1;
            mant_s    = q_q[QBITS-3:0];
        end
    end

    // Next-state logic for control, iteration registers and result outputs
    always_comb begin
        state_d     = state_q;
        spec_d      = spec_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        norm_d      = norm_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        exception_d = exception_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = a[31] ^ b[31];
                    ea_d   = a[30:23];
                    eb_d   = b[30:23];
                    mb_d   = {1'b1, b[22:0]};
                    rem_d  = {2'b01, a[22:0]};
                    q_d    = {QBITS{1'b0}};
                    cnt_d  = 5'd24;
                    norm_d = 1'b0;
                    // Specials are resolved one cycle later so they appear at accept+1
                    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (b[30:23] == 8'h00)) begin
                        spec_d = SPEC_INF;
                    end else if (a[30:23] == 8'h00) begin
                        spec_d = SPEC_ZERO;
                    end else begin
                        spec_d = SPEC_NONE;
                    end
                    state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (spec_q != SPEC_NONE) begin
                    quotient_d  = (spec_q == SPEC_INF) ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'h00, 23'd0};
                    exception_d = 1'b1;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    out_valid_d = 1'b1;
                    spec_d      = SPEC_NONE;
                    state_d     = ST_DONE;
                end else if (norm_q) begin
                    exception_d = 1'b0;
                    if (exp_adj_s >= 10'sd255) begin
                        quotient_d  = {sign_q, 8'hFF, 23'd0};
                        overflow_d  = 1'b1;
                        underflow_d = 1'b0;
                    end else if (exp_adj_s <= 10'sd0) begin
                        quotient_d  = {sign_q, 8'h00, 23'd0};
                        overflow_d  = 1'b0;
                        underflow_d = 1'b1;
                    end else begin
                        quotient_d  = {sign_q, exp_adj_s[7:0], mant_s};
                        overflow_d  = 1'b0;
                        underflow_d = 1'b0;
                    end
                    out_valid_d = 1'b1;
                    norm_d      = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    q_d   = {q_q[QBITS-2:0], rem_ge_s};
                    rem_d = rem_sel_s << 1;
                    if (cnt_q == 5'd0) begin
                        norm_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    exception_d = 1'b0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            spec_q      <= SPEC_NONE;
            sign_q      <= 1'b0;
            ea_q        <= 8'd0;
            eb_q        <= 8'd0;
            mb_q        <= 24'd0;
            rem_q       <= 25'd0;
            q_q         <= {QBITS{1'b0}};
            cnt_q       <= 5'd0;
            norm_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= 32'd0;
            exception_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            spec_q      <= spec_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            norm_q      <= norm_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            exception_q <= exception_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign exception = exception_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expectations queued at accept, compared when out_valid rises.
module tb_fp_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic        exception;
    logic        overflow;
    logic        underflow;

    typedef struct packed {
        logic [31:0] q;
        logic [2:0]  flags;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    fp_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // flags = {exception, overflow, underflow}; starts and ends on a negedge
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic [31:0] exp_q,
                          input logic [2:0] flags, input logic [7:0] lat, input int hold);
        exp_t e;
        exp_t x;
        int   k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before", 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        e.q = exp_q;
        e.flags = flags;
        e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h00000000;
        k = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        x = sb_q.pop_front();
        chk("latency", 64'(k), 64'(x.lat));
        chk("quotient", 64'(quotient), 64'(x.q));
        chk("flags", 64'({exception, overflow, underflow}), 64'(x.flags));
        if (hold > 0) begin
            in_valid = 1'b1;
            a = 32'h3F800000;
            b = 32'h3F800000;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_quotient", 64'(quotient), 64'(x.q));
                chk("hold_flags", 64'({exception, overflow, underflow}), 64'(x.flags));
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("ack_out_valid", 64'(out_valid), 64'd0);
        chk("ack_in_ready", 64'(in_ready), 64'd1);
        chk("ack_flags", 64'({exception, overflow, underflow}), 64'd0);
    endtask

    initial begin
        clk = 1'b0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'd0;
        b = 32'd0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_flags", 64'({exception, overflow, underflow}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 8'd26, 0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 8'd26, 0);
        run_op(32'hBF800000, 32'h3F000000, 32'hC0000000, 3'b000, 8'd26, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 8'd1, 0);
        run_op(32'h00000000, 32'h3F800000, 32'h00000000, 3'b100, 8'd1, 0);
        run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b100, 8'd1, 0);
        run_op(32'hFFC00000, 32'h3F800000, 32'hFF800000, 3'b100, 8'd1, 0);
        run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 3'b010, 8'd26, 0);
        run_op(32'h00800000, 32'h7F000000, 32'h00000000, 3'b001, 8'd26, 0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 8'd26, 10);

        // Reset in the middle of a division
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        chk("midrst_flags", 64'({exception, overflow, underflow}), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 8'd26, 0);

        repeat (3) @(negedge clk);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
